seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Downstream output stage of `top`. It takes a binary result value, such as a solver step count or a region/colour code, and converts it to BCD with a sequential double-dabble.
- It drives a 4-digit multiplexed 7-segment display through `num` and `n_mask`.
- It uses a load/busy handshake so that a new value never corrupts a conversion already in progress.

Parameters:
- SCAN_DIV, 4: clock cycles each digit stays enabled before the scan advances (must be ≥ 1).
- BIN_W, 14: width of `value`; values above 9999 are flagged as overflow.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- load  in  1  one-cycle request to capture `value`; honoured only when busy=0.
- value  in  BIN_W  binary value to display.
- busy  out  1  high while a conversion is in progress.
- overflow  out  1  set when the last accepted value was >9999.
- num  out  7  segments {g,f,e,d,c,b,a}, active-low.
- n_mask  out  4  digit enables, active-low one-hot; bit0 is the least significant digit.

Behaviour:
- Reset, on the rising edge with rst=1:
  - busy=0, overflow=0, num=7'h7F, n_mask=4'hF.
  - Digit registers d3..d0 = 0, scan index=0, divider=0.
  - Conversion FSM goes to IDLE.
  - Reset overrides everything, including a conversion in flight. That conversion is discarded and the display shows "0".
- FSM has three states: IDLE, CONV, COMMIT.
- IDLE:
  - load=1 captures `value` into the shift register, clears the 16-bit BCD accumulator and sets bit-counter=BIN_W.
  - Overflow is evaluated here: ovf_pend = (value>9999).
  - Next state is CONV and busy goes to 1 on the next cycle.
- CONV, one bit per cycle:
  - First, each BCD nibble ≥5 gets +3.
  - Then {bcd, shift} shifts left 1 and bit-counter decrements.
  - After BIN_W cycles the FSM moves to COMMIT.
- COMMIT, one cycle:
  - If ovf_pend=0, d3..d0 ← BCD nibbles. Otherwise all four digits are set to DASH.
  - overflow ← ovf_pend. busy ← 0 at the end of this cycle. Next state is IDLE.
- Handshake timing:
  - If load is sampled at edge t, busy is high from edge t+1 through edge t+BIN_W+1, i.e. BIN_W+1 cycles.
  - New digits appear on the outputs from edge t+BIN_W+2.
  - load while busy=1 is ignored; the value is not queued.
  - load in the same cycle busy falls is also ignored; the FSM must be in IDLE when load is sampled.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the scan index increments modulo 4 (3→0).
  - The scan runs continuously, independent of the FSM, starting from index 0 after reset.
- Outputs (registered):
  - n_mask ← ~(4'b0001 << index). num ← the segment code for d[index].
  - Outputs therefore lag the index by one cycle. The first cycle after reset release shows digit 0.
- Leading-zero blanking:
  - Digit k>0 shows blank (7'h7F) when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - DASH digits are never blanked.
- Segment codes (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - DASH=3F. Blank=7F.
- A display update in COMMIT takes effect on the next output register update, even mid-digit. Glitching of one digit period is acceptable.

Test Plan:
- rst high for 10 cycles, then low → n_mask cycles E,D,B,7, each held 4 cycles. num=40 while n_mask=E and 7F otherwise. busy=0, overflow=0.
- load=1 with value=1234 → busy high for exactly 15 cycles. Afterwards the n_mask E/D/B/7 phases show num 19/30/24/79 respectively.
- value=7 → digit0 shows 78; digits 1–3 show 7F. Then value=1000 → digit0..digit3 show 40, 40, 40, 79 (zeros not blanked below a nonzero digit).
- value=12000 → overflow=1 and all four digits show 3F. A following load of 5 → overflow=0 and digit0 shows 12.
- load value=9999, then pulse load value=42 during busy → the display ends at 9999 (num=10 on all digits) and 42 is never shown. A repeated load after busy=0 shows 42.
- load value=8888, then assert rst on the 5th busy cycle → busy=0 next edge, digits return to "0", and the scan index restarts at 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - binary to BCD converter driving a 4-digit multiplexed 7-segment display
module seg_scan_driver #(
  parameter int SCAN_DIV = 4,
  parameter int BIN_W    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             overflow,
  output logic [6:0]       num,
  output logic [3:0]       n_mask
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Internal digit code for the dash glyph; any nonzero code keeps it out of blanking.
  localparam logic [3:0] DIG_DASH = 4'hA;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  // Conversion state
  state_t           state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  // Displayed digits, d[0] is least significant
  logic [3:0]       dig_q [4];
  logic [3:0]       dig_d [4];

  // Scan state and registered display outputs
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       n_mask_q, n_mask_d;
  logic [6:0]       num_q, num_d;
  logic [3:0]       blank;
  logic             lz;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one digit code.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:     s = 7'h40;
      4'd1:     s = 7'h79;
      4'd2:     s = 7'h24;
      4'd3:     s = 7'h30;
      4'd4:     s = 7'h19;
      4'd5:     s = 7'h12;
      4'd6:     s = 7'h02;
      4'd7:     s = 7'h78;
      4'd8:     s = 7'h00;
      4'd9:     s = 7'h10;
      DIG_DASH: s = 7'h3F;
      default:  s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble add-3 correction applied before every shift.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next state: capture in IDLE, one bit per cycle in CONV, publish in COMMIT.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    dig_d      = dig_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d    = value;
          bcd_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = (32'(value) > 32'd9999);
          busy_d     = 1'b1;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        {bcd_d, shift_d} = {adj, shift_q} << 1;
        cnt_d            = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        for (int k = 0; k < 4; k++) begin
          dig_d[k] = ovf_pend_q ? DIG_DASH : bcd_q[4*k +: 4];
        end
        overflow_d = ovf_pend_q;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Leading-zero blanking: a digit above d0 blanks when it and every higher digit are zero.
  always_comb begin
    blank = 4'b0000;
    lz    = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      lz = lz & (dig_q[k] == 4'd0);
      if (k != 0) begin
        blank[k] = lz;
      end
    end
  end

  // Free-running scan divider/index and the next registered digit drive.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    n_mask_d = ~(4'b0001 << idx_q);
    num_d    = blank[idx_q] ? SEG_BLANK : seg_code(dig_q[idx_q]);
  end

  // All state registers; reset discards any conversion in flight and shows "0".
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        dig_q[k] <= 4'd0;
      end
      div_q      <= '0;
      idx_q      <= 2'd0;
      n_mask_q   <= 4'hF;
      num_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < 4; k++) begin
        dig_q[k] <= dig_d[k];
      end
      div_q      <= div_d;
      idx_q      <= idx_d;
      n_mask_q   <= n_mask_d;
      num_q      <= num_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign num      = num_q;
  assign n_mask   = n_mask_q;

endmodule
